// File: rtl/rs_bank_pkg.sv
// Shared constants and types for the rs_flag_bank flag cells.
// MODE selects conflict resolution, EDGE selects level or rising-edge request sampling.
package rs_bank_pkg;

  localparam int unsigned RS_RDOM   = 0;
  localparam int unsigned RS_SDOM   = 1;
  localparam int unsigned RS_TOGGLE = 2;

  localparam int unsigned RS_LEVEL = 0;
  localparam int unsigned RS_EDGE  = 1;

  // Encoded as {set_ev, rst_ev} so the pair can be cast directly.
  typedef enum logic [1:0] {
    EvNone = 2'b00,
    EvRst  = 2'b01,
    EvSet  = 2'b10,
    EvBoth = 2'b11
  } rs_ev_e;

  function automatic logic resolve_conflict(int unsigned mode, logic q_cur);
    logic res;
    unique case (mode)
      RS_SDOM:   res = 1'b1;
      RS_TOGGLE: res = ~q_cur;
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rs_cell.sv
// One set/reset flag channel: edge history, event decode, and complementary q/qn registers.
// rise flags a 0->1 transition of q on the coming edge; conflict flags a set/reset collision.
module rs_cell
  import rs_bank_pkg::*;
#(
  parameter int unsigned NR   = 2,
  parameter int unsigned MODE = RS_RDOM,
  parameter int unsigned EDGE = RS_LEVEL
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          s,
  input  logic [NR-1:0] r,
  output logic          q,
  output logic          qn,
  output logic          rise,
  output logic          conflict
);

  logic   q_q, q_d;
  logic   qn_q;
  logic   s_d_q, rsum_d_q;
  logic   rsum;
  logic   set_ev, rst_ev;
  rs_ev_e ev;

  always_comb begin
    rsum   = |r;
    set_ev = (EDGE == RS_EDGE) ? (s & ~s_d_q) : s;
    rst_ev = (EDGE == RS_EDGE) ? (rsum & ~rsum_d_q) : rsum;
    ev     = rs_ev_e'({set_ev, rst_ev});
  end

  always_comb begin
    q_d = q_q;
    unique case (ev)
      EvSet:   q_d = 1'b1;
      EvRst:   q_d = 1'b0;
      EvBoth:  q_d = resolve_conflict(MODE, q_q);
      default: q_d = q_q;
    endcase
    if (clr) begin
      q_d = 1'b0;
    end
  end

  always_comb begin
    conflict = (ev == EvBoth) & ~clr;
    rise     = q_d & ~q_q;
  end

  // History keeps sampling through clr so edges stay relative to the real input.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_q      <= 1'b0;
      qn_q     <= 1'b1;
      s_d_q    <= 1'b0;
      rsum_d_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      qn_q     <= ~q_d;
      s_d_q    <= s;
      rsum_d_q <= rsum;
    end
  end

  assign q  = q_q;
  assign qn = qn_q;

endmodule

// File: rtl/rs_flag_bank.sv
// Bank of CH set/reset flag cells with a saturating conflict counter and an
// acknowledged rising-edge interrupt. clr overrides every other input.
module rs_flag_bank
  import rs_bank_pkg::*;
#(
  parameter int unsigned CH    = 4,
  parameter int unsigned NR    = 2,
  parameter int unsigned MODE  = RS_RDOM,
  parameter int unsigned EDGE  = RS_LEVEL,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CH-1:0]    s,
  input  logic [CH*NR-1:0] r,
  input  logic             clr,
  input  logic             irq_ack,
  output logic [CH-1:0]    q,
  output logic [CH-1:0]    qn,
  output logic             irq,
  output logic [CH-1:0]    irq_src,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [CH-1:0]    rise;
  logic [CH-1:0]    conflict;
  logic [CH-1:0]    irq_src_q, irq_src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  for (genvar i = 0; i < CH; i++) begin : g_cell
    rs_cell #(
      .NR   (NR),
      .MODE (MODE),
      .EDGE (EDGE)
    ) u_cell (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (clr),
      .s        (s[i]),
      .r        (r[i*NR +: NR]),
      .q        (q[i]),
      .qn       (qn[i]),
      .rise     (rise[i]),
      .conflict (conflict[i])
    );
  end

  // An ack drops only bits already pending; a rise in the same cycle survives.
  always_comb begin
    irq_src_d = irq_src_q;
    if (clr) begin
      irq_src_d = '0;
    end else if (irq_ack) begin
      irq_src_d = rise;
    end else begin
      irq_src_d = irq_src_q | rise;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if ((|conflict) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_src_q <= '0;
      cnt_q     <= '0;
    end else begin
      irq_src_q <= irq_src_d;
      cnt_q     <= cnt_d;
    end
  end

  assign irq_src      = irq_src_q;
  assign irq          = |irq_src_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: doc/rs_flag_bank.md
# rs_flag_bank

Parametrised, clocked bank of set/reset flag cells: the synchronous, multi-channel successor to the lab's NOR-based RS latch. Each channel has one set input and NR OR-combined reset inputs. Set/reset conflicts resolve by a selectable mode, and Q/Qn are always complementary. The bank also counts conflicts and raises an acknowledged interrupt on flag rising edges, so it can collect status and error flags for the board-level FSM labs.

## Interface
Parameters:
- CH, 4: number of flag channels (1..32).
- NR, 2: reset inputs per channel (1..4).
- MODE, 0: conflict resolution. 0 = reset-dominant, 1 = set-dominant, 2 = toggle.
- EDGE, 0: 0 = level-sensitive S/R; 1 = rising-edge-sensitive S/R.
- CNT_W, 8: conflict counter width.

Ports:
- clk, in, 1: rising-edge clock.
- reset_n, in, 1: asynchronous, active-low reset.
- s, in, CH: set request, bit i belongs to channel i.
- r, in, CH*NR: reset requests. Bits [i*NR +: NR] belong to channel i.
- clr, in, 1: synchronous clear of the whole bank.
- irq_ack, in, 1: single-cycle interrupt acknowledge.
- q, out, CH: flag state.
- qn, out, CH: always ~q, registered. Never equal to q.
- irq, out, 1: |irq_src.
- irq_src, out, CH: pending rising-edge flags.
- conflict_cnt, out, CNT_W: saturating conflict counter.

## Operation
- Per channel, per cycle:
  - set_ev = s[i], or its rising edge when EDGE=1.
  - rst_ev = OR of the channel's NR r bits, or the rising edge of that OR when EDGE=1.
- Next q:
  - none: hold.
  - set only: 1.
  - reset only: 0.
  - both (conflict): MODE 0 → 0, MODE 1 → 1, MODE 2 → ~q.
- Edge history registers (s_d, rsum_d) sample every cycle, including during clr. They reset to 0. A level already high at reset release therefore counts as a rising edge on the first clock.
- conflict_cnt increments by 1 on each cycle where at least one channel is in conflict. The count does not depend on how many channels conflict. It saturates at 2^CNT_W-1.
- irq_src[i] is set on any cycle where q[i] goes 0→1, including a 0→1 produced by toggle mode.
- irq_ack clears only the irq_src bits already set in the ack cycle. A rising edge in the same cycle is kept, so the new edge wins.
- clr has priority over everything. q, irq_src and conflict_cnt go to 0; qn goes to all-ones. A set in the clr cycle is ignored, and the clr cycle is not counted as a conflict.

## Timing
- Reset values while reset_n=0, applied asynchronously:
  - q = 0, qn = all-ones.
  - irq = 0, irq_src = 0.
  - conflict_cnt = 0.
  - history registers = 0.
- Latency: a request sampled at edge k appears on q/qn after edge k, i.e. 1 cycle. irq_src and irq follow q in the same cycle; they are registered in parallel from next-q.
- Edge mode adds no latency: the edge is detected from the current input against the history register.
- Reset asserted mid-operation clears the bank immediately. The first update after release uses the inputs sampled at the first rising clk.
- Toggle mode with a conflict held in level mode alternates q every cycle, and each 0→1 sets irq_src.

## Structure
- Package rs_bank_pkg holds the MODE constants (RS_RDOM=0, RS_SDOM=1, RS_TOGGLE=2) and EDGE constants (RS_LEVEL=0, RS_EDGE=1).
- Sub-module rs_cell, instanced CH times, contains:
  - edge history, event logic, and the q/qn registers;
  - outputs rise (0→1 next cycle) and conflict.
- The top level (rs_flag_bank) holds the conflict counter, the irq_src/irq logic and the clr fan-out.

## Test plan
- Reset and basic set/reset (CH=4, NR=2, MODE=0, EDGE=0):
  - reset_n low gives q=0000, qn=1111, irq=0.
  - Releasing reset, then s=0001 for 1 cycle gives q=0001 one cycle later, irq_src=0001, irq=1.
- Multi-input reset: q=0001, then r=8'b00000010 (channel 0, input 1) gives q=0000 and conflict_cnt unchanged.
- Conflict modes: with s=0001 and r=00000001 held 3 cycles:
  - MODE 0: q[0]=0, conflict_cnt=3.
  - MODE 1: q[0]=1.
  - MODE 2: q[0] goes 1,0,1 and irq_src[0] is set twice.
- Edge mode (EDGE=1): s[1] held high 5 cycles after r clears q[1].
  - q[1] sets once.
  - A later single-cycle r pulse clears q[1] and it stays 0 while s[1] is still high.
- irq handshake:
  - irq_src=0011, irq_ack pulse gives irq_src=0000, irq=0.
  - irq_ack in the same cycle as a channel 2 rise gives irq_src=0100.
- Counter saturation and clr:
  - CNT_W=2 with 5 conflict cycles gives conflict_cnt=3.
  - A clr pulse during an active s gives q=0, irq=0, conflict_cnt=0 one cycle later.
